dmem_gpio: RTL



---
 rtl/dmem_gpio.sv | 117 +++++++++++
 1 files changed

// File: rtl/dmem_gpio.sv
// Data RAM plus an NCH-channel GPIO window. Reads are registered-address, combinational-data (1 cycle).
// No backpressure. Build with DMEM_GPIO_BOTH_EDGE_EN defined to also capture falling edges.
module dmem_gpio #(
    parameter int DW = 16,
    parameter int AW = 16,
    parameter int MEM_AW = 12,
    parameter int NCH = 2,
    parameter logic [AW-1:0] IO_BASE = 16'h100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     din,
    input  logic [AW-1:0]     addr,
    input  logic              we,
    output logic [DW-1:0]     dout,
    input  logic [NCH*DW-1:0] gpio_in,
    output logic [NCH*DW-1:0] gpio_out,
    output logic [NCH*DW-1:0] gpio_oe,
    output logic              irq
);
    localparam logic [AW-1:0] OFF_ST  = AW'(4 * NCH);
    localparam logic [AW-1:0] OFF_IEN = AW'(4 * NCH + 1);
    localparam logic [AW-1:0] IO_LAST = IO_BASE + OFF_IEN;

    logic [DW-1:0]     mem [0:(1<<MEM_AW)-1];
    logic [AW-1:0]     addr_r;
    logic [AW-1:0]     wr_off;
    logic [AW-1:0]     rd_off;
    logic              wr_io;
    logic              rd_io;
    logic [NCH*DW-1:0] s1, s2, prev;
    logic [NCH*DW-1:0] out_r, dir_r, edge_r;
    logic [NCH*DW-1:0] ev, clr;
    logic [NCH-1:0]    ien, irq_st;

    // Full-width compare so RAM aliases of the window never decode as IO.
    assign wr_io  = (addr >= IO_BASE) && (addr <= IO_LAST);
    assign rd_io  = (addr_r >= IO_BASE) && (addr_r <= IO_LAST);
    assign wr_off = addr - IO_BASE;
    assign rd_off = addr_r - IO_BASE;

    assign gpio_out = out_r;
    assign gpio_oe  = dir_r;

`ifdef DMEM_GPIO_BOTH_EDGE_EN
    assign ev = (s2 ^ prev) & ~dir_r;
`else
    assign ev = s2 & ~prev & ~dir_r;
`endif

    always_comb begin
        irq_st = '0;
        clr    = '0;
        for (int c = 0; c < NCH; c++) begin
            irq_st[c] = (|edge_r[c*DW +: DW]) & ien[c];
            if (we && wr_io && (wr_off == AW'(4 * c + 3)))
                clr[c*DW +: DW] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !wr_io)
            mem[addr[MEM_AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r <= '0;
            s1     <= '0;
            s2     <= '0;
            prev   <= '0;
            out_r  <= '0;
            dir_r  <= '0;
            edge_r <= '0;
            ien    <= '0;
            irq    <= 1'b0;
        end else begin
            s1     <= gpio_in;
            s2     <= s1;
            prev   <= s2;
            // A new edge beats a simultaneous clear on the same bit.
            edge_r <= (edge_r & ~clr) | ev;
            irq    <= |irq_st;
            if (!we)
                addr_r <= addr;
            for (int c = 0; c < NCH; c++) begin
                if (we && wr_io && (wr_off == AW'(4 * c + 1)))
                    out_r[c*DW +: DW] <= din;
                if (we && wr_io && (wr_off == AW'(4 * c + 2)))
                    dir_r[c*DW +: DW] <= din;
            end
            if (we && wr_io && (wr_off == OFF_IEN))
                ien <= din[NCH-1:0];
        end
    end

    always_comb begin
        dout = mem[addr_r[MEM_AW-1:0]];
        if (rd_io) begin
            dout = '0;
            for (int c = 0; c < NCH; c++) begin
                if (rd_off == AW'(4 * c))
                    dout = s2[c*DW +: DW];
                if (rd_off == AW'(4 * c + 1))
                    dout = out_r[c*DW +: DW];
                if (rd_off == AW'(4 * c + 2))
                    dout = dir_r[c*DW +: DW];
                if (rd_off == AW'(4 * c + 3))
                    dout = edge_r[c*DW +: DW];
            end
            if (rd_off == OFF_ST)
                dout = DW'(irq_st);
            if (rd_off == OFF_IEN)
                dout = DW'(ien);
        end
    end
endmodule
